fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage sitting directly upstream of the instruction cache.
//  Generates sequential PCs, runs the cache's read_enable/send_enable/send_complete
//  handshake one word at a time, and buffers {pc, instr} pairs in a small FIFO for decode.
//  Handles branch redirects: flushes the FIFO and squashes any in-flight cache response.
// PARAMETERS
//  ADDR_WIDTH   64     PC / cache address width
//  INSTR_WIDTH  32     instruction width; taken from cache_data[INSTR_WIDTH-1:0]
//  RESET_PC     64'h0  PC loaded at reset
//  QUEUE_DEPTH  2      output FIFO entries (power of 2, >=2)
// PORTS
//  clock               in   1           single clock, all state on rising edge
//  reset               in   1           asynchronous, active-low reset
//  fetch_enable        in   1           1 = allowed to start new cache requests
//  redirect_valid      in   1           1-cycle pulse: branch/jump taken
//  redirect_pc         in   ADDR_WIDTH  new PC; bits [1:0] forced to 0
//  cache_read_enable   out  1           read request to cache
//  cache_address       out  ADDR_WIDTH  fetch address, stable while cache_read_enable=1
//  cache_data_size     out  3           constant 3'd4 (bytes)
//  cache_data          in   64          cache output word
//  cache_send_enable   in   1           cache: cache_data valid
//  cache_send_complete out  1           1-cycle ack to cache: data consumed
//  if_valid            out  1           FIFO head valid to decode
//  if_ready            in   1           decode accepts head this cycle
//  if_pc               out  ADDR_WIDTH  PC of head entry
//  if_instr            out  INSTR_WIDTH instruction of head entry
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, pc=RESET_PC, FIFO empty, squash=0; all outputs 0
//   except cache_data_size=4. Deassertion takes effect on next clock edge.
//  All outputs registered. FSM states:
//   IDLE:     if fetch_enable && (fifo_count < QUEUE_DEPTH) && !redirect_valid ->
//             latch cache_address=pc, cache_read_enable=1, go REQ.
//   REQ:      hold cache_read_enable=1, cache_address stable until cache_send_enable=1;
//             then capture cache_data[INSTR_WIDTH-1:0] with pc into FIFO (unless squashed),
//             pc<=pc+4, cache_read_enable<=0, cache_send_complete<=1, go COMPLETE.
//   COMPLETE: cache_send_complete high exactly this one cycle; go RELEASE.
//   RELEASE:  wait for cache_send_enable=0, then clear squash and go IDLE.
//  Never abandons a cache transaction mid-handshake: once REQ is entered it runs to RELEASE.
//  Slot reservation: IDLE only issues if a FIFO slot is free, so capture in REQ never overflows.
//  Latency: hit returning send_enable the cycle after read_enable -> if_valid 1 cycle after
//   capture edge; minimum 4 cycles per fetched word (IDLE,REQ,COMPLETE,RELEASE).
//  FIFO: push on capture, pop when if_valid && if_ready; simultaneous push/pop with FIFO full
//   is impossible (slot reserved); push+pop same cycle keeps count. Pointers wrap mod depth.
//  if_valid/if_pc/if_instr reflect FIFO head; head is stable while if_valid && !if_ready.
//  Redirect (any state): FIFO flushed (count=0, if_valid=0 next cycle), pc<=redirect_pc & ~3.
//   In IDLE: no request issued that cycle; next request from redirect_pc one cycle later.
//   In REQ/COMPLETE/RELEASE: squash=1; the in-flight word (even if captured same cycle) is
//   discarded; pc is NOT incremented by that capture; handshake still completes normally.
//  Redirect takes priority over pop and push in the same cycle.
//  pc arithmetic: modulo 2^ADDR_WIDTH, wraps silently.
//  fetch_enable=0 blocks only new requests; an in-flight request completes and is enqueued.
// TESTING
//  1 Reset, fetch_enable=1, cache returns send_enable 1 cycle after read_enable ->
//    addresses 0x0,0x4,0x8 issued; if_pc=0x0 with matching if_instr; send_complete 1-cycle pulses.
//  2 if_ready=0, 3 words available -> exactly 2 enqueued, cache_read_enable stays 0 until a pop.
//  3 redirect_valid with redirect_pc=0x1003 while in REQ -> in-flight word dropped, if_valid=0,
//    next cache_address=0x1000.
//  4 Cache holds send_enable 5 cycles after send_complete -> fetch stays in RELEASE, no new request.
//  5 Assert reset mid-REQ -> outputs cleared asynchronously; after release first address=RESET_PC.
//  6 pc=0xFFFF_FFFF_FFFF_FFFC fetch -> next cache_address=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: walks sequential PCs through the I-cache handshake one word
// at a time and queues {pc, instr} pairs for decode, with branch redirect/flush support.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_enable,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   cache_read_enable,
  output logic [ADDR_WIDTH-1:0]  cache_address,
  output logic [2:0]             cache_data_size,
  input  logic [63:0]            cache_data,
  input  logic                   cache_send_enable,
  output logic                   cache_send_complete,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, COMPLETE, RELEASE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   squash;
  logic [ADDR_WIDTH-1:0]  fifo_pc    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr [QUEUE_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W:0]         count;
  logic [PTR_W:0]         count_next;

  logic                   slot_free;
  logic                   capture;
  logic                   push;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  redirect_target;
  logic                   unused_bits;

  assign cache_data_size = 3'd4;
  assign unused_bits     = ^{cache_data[63:INSTR_WIDTH], redirect_pc[1:0]};

  assign slot_free       = (count < DEPTH_CNT);
  assign capture         = (state == REQ) && cache_send_enable;
  assign push            = capture && !squash && !redirect_valid;
  assign pop             = if_valid && if_ready && !redirect_valid;
  assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  assign if_pc    = fifo_pc[rd_ptr];
  assign if_instr = fifo_instr[rd_ptr];

  always_comb begin
    count_next = count;
    if (redirect_valid)
      count_next = '0;
    else if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // Redirect empties the queue outright; push and pop are both suppressed that cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if_valid <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      count    <= count_next;
      if_valid <= (count_next != '0);
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]    <= pc;
          fifo_instr[wr_ptr] <= cache_data[INSTR_WIDTH-1:0];
          wr_ptr             <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Once a request is issued the handshake always runs to RELEASE; a redirect only
  // marks the in-flight word as squashed so it is dropped at capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      pc                  <= RESET_PC;
      squash              <= 1'b0;
      cache_read_enable   <= 1'b0;
      cache_address       <= '0;
      cache_send_complete <= 1'b0;
    end else begin
      cache_send_complete <= 1'b0;
      if (redirect_valid) begin
        pc <= redirect_target;
        if (state != IDLE)
          squash <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fetch_enable && slot_free && !redirect_valid) begin
            cache_address     <= pc;
            cache_read_enable <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (cache_send_enable) begin
            cache_read_enable   <= 1'b0;
            cache_send_complete <= 1'b1;
            state               <= COMPLETE;
            if (!squash && !redirect_valid)
              pc <= pc + ADDR_WIDTH'(4);
          end
        end
        COMPLETE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          if (!cache_send_enable) begin
            squash <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural I-cache answers requests, and two
// scoreboard monitors check issued addresses and words delivered to decode.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        cache_read_enable;
  logic [63:0] cache_address;
  logic [2:0]  cache_data_size;
  logic [63:0] cache_data;
  logic        send_en;
  logic        cache_send_complete;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } out_t;

  out_t        exp_out[$];
  logic [63:0] exp_addr[$];

  int vectors     = 0;
  int miscompares = 0;
  int addr_seen   = 0;

  int resp_delay  = 0;
  int hold_cycles = 0;
  int delay_cnt   = 0;
  int hold_cnt    = 0;
  logic holding   = 1'b0;

  logic        prev_re   = 1'b0;
  logic        prev_sc   = 1'b0;
  logic [63:0] held_addr = '0;

  fetch_unit dut (
    .clock              (clock),
    .reset              (reset),
    .fetch_enable       (fetch_enable),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .cache_read_enable  (cache_read_enable),
    .cache_address      (cache_address),
    .cache_data_size    (cache_data_size),
    .cache_data         (cache_data),
    .cache_send_enable  (send_en),
    .cache_send_complete(cache_send_complete),
    .if_valid           (if_valid),
    .if_ready           (if_ready),
    .if_pc              (if_pc),
    .if_instr           (if_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy);
    fetch_enable = fe;
    if_ready     = rdy;
  endtask

  task automatic expectAddr(input logic [63:0] a);
    exp_addr.push_back(a);
  endtask

  task automatic expectOut(input logic [63:0] p, input logic [31:0] ins);
    out_t e;
    e.pc    = p;
    e.instr = ins;
    exp_out.push_back(e);
  endtask

  task automatic waitAddrs(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (addr_seen >= target) begin
        done = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (!done)
      checkOutput("wait_addr_timeout", 64'(addr_seen), 64'(target));
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (exp_out.size() == 0 && exp_addr.size() == 0 && !if_valid &&
          !cache_read_enable && !send_en && !cache_send_complete) begin
        done = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clock);
    #1;
    checkOutput("drain_complete", 64'(done), 64'd1);
  endtask

  // Cache model: answers after resp_delay cycles, then holds send_enable for
  // hold_cycles after the ack before releasing.
  always @(negedge clock) begin
    if (!reset) begin
      send_en   = 1'b0;
      delay_cnt = 0;
      holding   = 1'b0;
    end else if (send_en) begin
      if (holding) begin
        if (hold_cnt <= 1) begin
          send_en = 1'b0;
          holding = 1'b0;
        end else begin
          hold_cnt--;
        end
      end else if (cache_send_complete) begin
        if (hold_cycles == 0) begin
          send_en = 1'b0;
        end else begin
          holding  = 1'b1;
          hold_cnt = hold_cycles;
        end
      end
    end else if (cache_read_enable) begin
      if (delay_cnt >= resp_delay) begin
        send_en    = 1'b1;
        cache_data = {32'hDEAD_BEEF, cache_address[31:0] ^ 32'h5A5A_0F0F};
        delay_cnt  = 0;
      end else begin
        delay_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset && cache_read_enable && !prev_re) begin
      addr_seen++;
      held_addr = cache_address;
      if (exp_addr.size() == 0)
        checkOutput("unexpected_request", cache_address, 64'hFFFF_FFFF_FFFF_FFFF);
      else
        checkOutput("cache_address", cache_address, exp_addr.pop_front());
    end else if (reset && cache_read_enable) begin
      checkOutput("address_stable", cache_address, held_addr);
    end
    if (reset && prev_sc)
      checkOutput("send_complete_pulse", 64'(cache_send_complete), 64'd0);
    prev_re = cache_read_enable;
    prev_sc = cache_send_complete;
  end

  always @(negedge clock) begin
    if (reset && if_valid && if_ready) begin
      if (exp_out.size() == 0) begin
        checkOutput("unexpected_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        out_t e;
        e = exp_out.pop_front();
        checkOutput("if_pc", if_pc, e.pc);
        checkOutput("if_instr", 64'(if_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    int re_count;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cache_data     = '0;
    send_en        = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_read_enable", 64'(cache_read_enable), 64'd0);
    checkOutput("reset_address", cache_address, 64'd0);
    checkOutput("reset_send_complete", 64'(cache_send_complete), 64'd0);
    checkOutput("reset_if_valid", 64'(if_valid), 64'd0);
    checkOutput("reset_if_pc", if_pc, 64'd0);
    checkOutput("reset_data_size", 64'(cache_data_size), 64'd4);

    // Sequential fetch from reset with single-cycle cache hits
    expectAddr(64'h0);
    expectAddr(64'h4);
    expectAddr(64'h8);
    expectOut(64'h0, 32'h5A5A_0F0F);
    expectOut(64'h4, 32'h5A5A_0F0B);
    expectOut(64'h8, 32'h5A5A_0F07);
    applyStimulus(1'b1, 1'b1);
    reset = 1'b1;
    waitAddrs(3);
    applyStimulus(1'b0, 1'b1);
    waitDrain();

    // Decode stalled: only QUEUE_DEPTH words fetched, then resume after pops
    expectAddr(64'hC);
    expectAddr(64'h10);
    expectOut(64'hC, 32'h5A5A_0F03);
    expectOut(64'h10, 32'h5A5A_0F1F);
    applyStimulus(1'b1, 1'b0);
    waitAddrs(5);
    repeat (6) @(posedge clock);
    #1;
    checkOutput("full_if_valid", 64'(if_valid), 64'd1);
    checkOutput("full_head_pc", if_pc, 64'hC);
    checkOutput("full_head_instr", 64'(if_instr), 64'h5A5A_0F03);
    seen = addr_seen;
    repeat (8) @(posedge clock);
    #1;
    checkOutput("full_no_request", 64'(addr_seen), 64'(seen));
    checkOutput("full_read_enable", 64'(cache_read_enable), 64'd0);
    expectAddr(64'h14);
    expectOut(64'h14, 32'h5A5A_0F1B);
    applyStimulus(1'b1, 1'b1);
    waitAddrs(6);
    applyStimulus(0, 1'b1);
    waitDrain();

    // Redirect while a request is outstanding squashes that word
    resp_delay = 3;
    expectAddr(64'h18);
    expectAddr(64'h1000);
    expectOut(64'h1000, 32'h5A5A_1F0F);
    applyStimulus(1'b1, 1'b1);
    waitAddrs(7);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    checkOutput("redirect_if_valid", 64'(if_valid), 64'd0);
    waitAddrs(8);
    applyStimulus(1'b0, 1'b1);
    waitDrain();

    // Cache holds send_enable after the ack: no new request until it drops
    resp_delay  = 0;
    hold_cycles = 5;
    expectAddr(64'h1004);
    expectAddr(64'h1008);
    expectOut(64'h1004, 32'h5A5A_1F0B);
    expectOut(64'h1008, 32'h5A5A_1F07);
    applyStimulus(1'b1, 1'b1);
    waitAddrs(9);
    for (int i = 0; i < 20; i++) begin
      if (cache_send_complete) break;
      @(posedge clock);
      #1;
    end
    seen     = addr_seen;
    re_count = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      if (cache_read_enable) re_count++;
    end
    hold_cycles = 0;
    checkOutput("release_no_read_enable", 64'(re_count), 64'd0);
    checkOutput("release_no_request", 64'(addr_seen), 64'(seen));
    waitAddrs(10);
    applyStimulus(1'b0, 1'b1);
    waitDrain();

    // Asynchronous reset in the middle of a request
    resp_delay = 3;
    expectAddr(64'h100C);
    applyStimulus(1'b1, 1'b1);
    waitAddrs(11);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_read_enable", 64'(cache_read_enable), 64'd0);
    checkOutput("async_reset_address", cache_address, 64'd0);
    checkOutput("async_reset_if_valid", 64'(if_valid), 64'd0);
    expectAddr(64'h0);
    expectOut(64'h0, 32'h5A5A_0F0F);
    @(posedge clock);
    #1;
    reset = 1'b1;
    waitAddrs(12);
    applyStimulus(1'b0, 1'b1);
    waitDrain();
    resp_delay = 0;

    // Redirect in IDLE to the top of memory; pc wraps to zero
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    expectAddr(64'hFFFF_FFFF_FFFF_FFFC);
    expectAddr(64'h0);
    expectOut(64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5_F0F3);
    expectOut(64'h0, 32'h5A5A_0F0F);
    applyStimulus(1'b1, 1'b1);
    waitAddrs(14);
    applyStimulus(1'b0, 1'b1);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
